// File: rtl/pipe_adder_if.sv
// pipe_adder_if: operand and result handshake bundle for the pipelined adder.
// The master side offers operands and consumes results; the slave side is the adder.
interface pipe_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipe_adder.sv
// pipe_adder: WIDTH-bit add/subtract resolved SEG bits per pipeline stage.
// Each stage ripples one segment and registers its carry for the next stage.
// The operand-A word doubles as the result word: stage k overwrites segment k
// of it with the partial sum, so finished sum bits and pending A bits travel
// together. The not-yet-used part of B travels in a shrinking skew register.
// WIDTH must be a multiple of SEG. The last stage register is the output.
// A single global advance enable keeps the whole pipe in lockstep: it moves
// whenever the output slot is empty or being drained, otherwise everything holds.
module pipe_adder #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input logic         clk,
  input logic         reset,
  pipe_adder_if.slave bus
);
  localparam int STAGES = WIDTH / SEG;

  logic             adv_s;
  logic             accept_s;
  logic [WIDTH-1:0] beff_s;
  logic             ceff_s;
  logic             last_vld_s;

  // Subtraction is a + ~b + ~cin, so conditioning happens once at the input.
  always_comb begin
    if (bus.sub) begin
      beff_s = ~bus.b;
      ceff_s = ~bus.cin;
    end else begin
      beff_s = bus.b;
      ceff_s = bus.cin;
    end
  end

  // Whole-pipe advance: move when the output is empty or being taken.
  always_comb begin
    adv_s    = !last_vld_s || bus.out_ready;
    accept_s = bus.in_valid && adv_s;
  end

  assign bus.in_ready = adv_s;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SEG;
    localparam int HI = LO + SEG - 1;

    logic             vld_r;
    logic             c_r;
    logic [WIDTH-1:0] acc_r;

    logic             v_in_s;
    logic             c_in_s;
    logic [WIDTH-1:0] acc_in_s;
    logic [SEG-1:0]   bseg_s;
    logic [SEG:0]     seg_s;
    logic [WIDTH-1:0] acc_nxt_s;

    if (k == 0) begin : g_src
      assign v_in_s   = accept_s;
      assign c_in_s   = ceff_s;
      assign acc_in_s = bus.a;
      assign bseg_s   = beff_s[HI:LO];
    end else begin : g_src
      assign v_in_s   = g_stage[k-1].vld_r;
      assign c_in_s   = g_stage[k-1].c_r;
      assign acc_in_s = g_stage[k-1].acc_r;
      assign bseg_s   = g_stage[k-1].g_skew.b_r[HI:LO];
    end

    // Ripple this stage's segment and splice it into the travelling word.
    always_comb begin
      seg_s     = {1'b0, acc_in_s[HI:LO]} + {1'b0, bseg_s} + {{SEG{1'b0}}, c_in_s};
      acc_nxt_s = acc_in_s;
      acc_nxt_s[HI:LO] = seg_s[SEG-1:0];
    end

    // Stage register: valid, partial word and segment carry-out.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vld_r <= 1'b0;
        c_r   <= 1'b0;
        acc_r <= {WIDTH{1'b0}};
      end else if (adv_s) begin
        vld_r <= v_in_s;
        c_r   <= seg_s[SEG];
        acc_r <= acc_nxt_s;
      end
    end

    if (k < STAGES - 1) begin : g_skew
      logic [WIDTH-1:HI+1] b_r;
      logic [WIDTH-1:HI+1] b_in_s;

      if (k == 0) begin : g_bsrc
        assign b_in_s = beff_s[WIDTH-1:HI+1];
      end else begin : g_bsrc
        assign b_in_s = g_stage[k-1].g_skew.b_r[WIDTH-1:HI+1];
      end

      // Carry the still-unused upper segments of B alongside the stage.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          b_r <= {(WIDTH-HI-1){1'b0}};
        end else if (adv_s) begin
          b_r <= b_in_s;
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic ovf_r;
      logic cmsb_s;

      // The carry into the MSB is recovered from the MSB's own sum equation.
      always_comb begin
        cmsb_s = acc_in_s[WIDTH-1] ^ bseg_s[SEG-1] ^ seg_s[SEG-1];
      end

      // Signed overflow: carry into the MSB differs from carry out of it.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          ovf_r <= 1'b0;
        end else if (adv_s) begin
          ovf_r <= cmsb_s ^ seg_s[SEG];
        end
      end
    end
  end

  assign last_vld_s    = g_stage[STAGES-1].vld_r;
  assign bus.out_valid = last_vld_s;
  assign bus.sum       = g_stage[STAGES-1].acc_r;
  assign bus.cout      = g_stage[STAGES-1].c_r;
  assign bus.ovf       = g_stage[STAGES-1].g_last.ovf_r;

endmodule
